// File: rtl/agent_pkg.sv
// Shared types and constants for the SEIR contact-graph agent.
package agent_pkg;

    typedef enum logic [1:0] {
        SUS = 2'd0,
        EXP = 2'd1,
        INF = 2'd2,
        REC = 2'd3
    } state_t;

    localparam logic [31:0] RECOV_THRESH_DEF  = 32'h4CCCCCCC;
    localparam logic [31:0] INFECT_THRESH_DEF = 32'hCCCCCCCC;

    function automatic logic [31:0] bcast_addr(input int w);
        return 32'((64'd1 << w) - 64'd1);
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/agent_seir_prbs.sv
// Free-running 32-bit Galois LFSR with a threshold draw.
module prbs #(
    parameter logic [31:0] SEED   = 32'd0,
    parameter logic [31:0] THRESH = 32'hCCCCCCCC,
    parameter int          TYPE   = 1
) (
    input  logic clk,
    output logic hit
);

    localparam logic [31:0] MIX  = 32'h1D872B41;
    localparam logic [31:0] TAPS = 32'h80200003;

    logic [31:0] lfsr;

    // Not reset: an all-zero state reseeds itself instead of locking up.
    always_ff @(posedge clk) begin
        if (lfsr == 32'd0)
            lfsr <= SEED ^ MIX;
        else
            lfsr <= {1'b0, lfsr[31:1]} ^ (lfsr[0] ? TAPS : 32'd0);
    end

    generate
        if (TYPE == 1) begin : g_thresh
            assign hit = (lfsr <= THRESH);
        end else begin : g_raw
            assign hit = lfsr[0];
        end
    endgenerate

endmodule

// File: rtl/agent_seir.sv
// One SEIR node of the epidemic fabric: step-gated FSM, loading and event counter.
module agent_seir
    import agent_pkg::*;
#(
    parameter int                  NODE_ADDR     = 0,
    parameter int                  NUM_NBR       = 10,
    parameter logic [NUM_NBR-1:0]  CONNECTIVITY  = 'h23,
    parameter int                  ADDR_W        = 4,
    parameter int                  EXP_STEPS     = 2,
    parameter int                  INF_MIN_STEPS = 1,
    parameter int                  IMMUNE_STEPS  = 3,
    parameter logic [31:0]         RECOV_THRESH  = RECOV_THRESH_DEF,
    parameter logic [31:0]         INFECT_THRESH = INFECT_THRESH_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               step,
    input  logic [NUM_NBR-1:0] neighbourEdges,
    output logic [NUM_NBR-1:0] outputEdges,
    input  logic [ADDR_W-1:0]  address,
    input  logic               loadState,
    input  logic [1:0]         initState,
    output logic [1:0]         currState,
    output logic [15:0]        infectCount
);

    localparam int TW = $clog2(max2(max2(EXP_STEPS, INF_MIN_STEPS),
                                    max2(IMMUNE_STEPS, 2)));
    localparam logic [TW-1:0] EXP_ENT = (EXP_STEPS == 0) ? '0 : TW'(EXP_STEPS - 1);
    localparam logic [TW-1:0] INF_ENT = (INF_MIN_STEPS == 0) ? '0 : TW'(INF_MIN_STEPS - 1);
    localparam logic [TW-1:0] IMM_ENT = (IMMUNE_STEPS == 0) ? '0 : TW'(IMMUNE_STEPS - 1);
    localparam logic [ADDR_W-1:0] BCAST = ADDR_W'(bcast_addr(ADDR_W));

    state_t             state;
    logic [TW-1:0]      timer;
    logic [15:0]        infect_cnt;
    logic               recover;
    logic [NUM_NBR-1:0] infect_gen;
    logic               load_hit;

    function automatic logic [TW-1:0] entry(input state_t s);
        case (s)
            EXP:     return EXP_ENT;
            INF:     return INF_ENT;
            REC:     return IMM_ENT;
            default: return '0;
        endcase
    endfunction

    prbs #(
        .SEED   (32'(NODE_ADDR)),
        .THRESH (RECOV_THRESH),
        .TYPE   (1)
    ) u_recov (
        .clk (clk),
        .hit (recover)
    );

    for (genvar i = 0; i < NUM_NBR; i++) begin : g_edge
        prbs #(
            .SEED   (32'(NODE_ADDR * NUM_NBR + i + 1)),
            .THRESH (INFECT_THRESH),
            .TYPE   (1)
        ) u_inf (
            .clk (clk),
            .hit (infect_gen[i])
        );
    end

    assign load_hit = loadState &&
                      (address == ADDR_W'(NODE_ADDR) || address == BCAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= SUS;
            timer      <= '0;
            infect_cnt <= '0;
        end else if (load_hit) begin
            state      <= state_t'(initState);
            timer      <= entry(state_t'(initState));
            infect_cnt <= '0;
        end else if (step) begin
            unique case (state)
                SUS: begin
                    if (|neighbourEdges) begin
                        if (EXP_STEPS == 0) begin
                            state <= INF;
                            timer <= INF_ENT;
                        end else begin
                            state <= EXP;
                            timer <= EXP_ENT;
                        end
                        if (infect_cnt != 16'hFFFF)
                            infect_cnt <= infect_cnt + 16'd1;
                    end
                end
                EXP: begin
                    if (timer != '0) begin
                        timer <= timer - TW'(1);
                    end else begin
                        state <= INF;
                        timer <= INF_ENT;
                    end
                end
                INF: begin
                    if (timer != '0) begin
                        timer <= timer - TW'(1);
                    end else if (recover) begin
                        state <= (IMMUNE_STEPS == 0) ? SUS : REC;
                        timer <= IMM_ENT;
                    end
                end
                REC: begin
                    if (timer != '0) begin
                        timer <= timer - TW'(1);
                    end else begin
                        state <= SUS;
                        timer <= '0;
                    end
                end
            endcase
        end
    end

    // Not step-gated: the fabric samples edges only on step cycles.
    assign outputEdges = (state == INF) ? (CONNECTIVITY & infect_gen) : '0;
    assign currState   = state;
    assign infectCount = infect_cnt;

endmodule

// File: doc/agent_seir.md
Name: agent_seir

Overview:
- Parametrised successor of the two-state disease agent: one node of the contact-graph epidemic fabric.
- Four-state compartment model: SUS→EXP→INF→REC→SUS.
- Neighbour count, edge connectivity, exposure latency, minimum infectious dwell, immunity period and probability thresholds are all parameters.
- Adds step-gated advance, address-matched loading, and a saturating per-node infection-event counter, which the fabric statistics collector reads.

Parameters:
- NODE_ADDR, 0, node address for load matching.
- NUM_NBR, 10, number of neighbour/output edges.
- CONNECTIVITY, 'h23, NUM_NBR-bit mask of outgoing edges.
- ADDR_W, 4, address bus width; the all-ones address is broadcast.
- EXP_STEPS, 2, steps spent in EXP; 0 means skip EXP.
- INF_MIN_STEPS, 1, steps in INF before recovery may occur.
- IMMUNE_STEPS, 3, steps spent in REC; 0 means skip REC.
- RECOV_THRESH, 32'h4CCCCCCC, prbs threshold for the recovery draw.
- INFECT_THRESH, 32'hCCCCCCCC, prbs threshold for each edge transmission draw.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- step, input, 1, simulation-step strobe; the state machine advances only when it is 1.
- neighbourEdges, input, NUM_NBR, transmission edges from neighbours.
- outputEdges, output, NUM_NBR, transmission edges to neighbours.
- address, input, ADDR_W, load target address.
- loadState, input, 1, load strobe.
- initState, input, 2, state value to load (0 SUS, 1 EXP, 2 INF, 3 REC).
- currState, output, 2, current state.
- infectCount, output, 16, number of SUS→EXP/INF transitions.

Behaviour:
- Reset (rst_n=0, asynchronous): state=SUS, timer=0, infectCount=0. Consequently currState=0 and outputEdges=0. Reset asserted mid-step aborts the step with no partial update.
- Load
  - The load condition is loadState=1 and (address==NODE_ADDR or address is all ones).
  - On load: state←initState; timer←the entry value for that state (see below); infectCount←0.
  - Load has priority over step in the same cycle.
  - loadState with a non-matching address is ignored, and step behaviour proceeds normally.
- Step: when step=1 and no load, exactly one transition evaluation occurs. When step=0, state and timer hold.
- SUS
  - If |neighbourEdges: go to EXP with timer=EXP_STEPS-1, and infectCount increments.
  - If EXP_STEPS=0: go directly to INF with timer=INF_MIN_STEPS-1, and infectCount still increments.
- EXP
  - timer≠0: decrement the timer.
  - timer=0: go to INF with timer=INF_MIN_STEPS-1. If INF_MIN_STEPS=0, timer=0.
  - neighbourEdges are ignored.
- INF
  - timer≠0: decrement the timer; recovery is suppressed.
  - timer=0 and recover=1: go to REC with timer=IMMUNE_STEPS-1.
  - If IMMUNE_STEPS=0: go to SUS instead of REC.
- REC
  - timer≠0: decrement the timer.
  - timer=0: go to SUS.
  - neighbourEdges are ignored.
- outputEdges: combinational. It equals CONNECTIVITY & infectGen[NUM_NBR-1:0] when state==INF, else 0. It is not gated by step, because the fabric samples it on the step cycle only.
- PRBS generators
  - The recover bit comes from a prbs instance with seed=NODE_ADDR, threshold=RECOV_THRESH, type=1.
  - Each infectGen[i] comes from a prbs instance with seed=NODE_ADDR*NUM_NBR+i+1, threshold=INFECT_THRESH, type=1.
  - All generators are free-running every clk and are not reset by rst_n.
- infectCount: 16-bit, saturates at 16'hFFFF with no wrap.
- Timer width: $clog2 of max(EXP_STEPS, INF_MIN_STEPS, IMMUNE_STEPS, 2). Entry values for a duration of 0 clamp to 0.
- Latency: a state change is visible on currState on the clk edge after step is sampled. outputEdges follows in the same cycle.

Decomposition:
- Package agent_pkg holds:
  - the state encoding constants SUS/EXP/INF/REC and the 2-bit state typedef;
  - the default thresholds;
  - the broadcast address function.
- The natural sub-module is the existing prbs generator, instantiated 1+NUM_NBR times.
- A small agent_timer (load/decrement/zero-flag) sub-module is optional.

Test Plan:
- Reset and load: hold rst_n=0, then release and apply load with address=NODE_ADDR, initState=2. Required: currState=0 and infectCount=0 during reset, then currState=2 next cycle. Apply load with address=5 when NODE_ADDR=0: required to be ignored. Apply load with address=4'hF: required to load (broadcast).
- Infection and timing: in SUS, drive neighbourEdges=10'h001 with step held high. Required sequence with EXP_STEPS=2 and INF_MIN_STEPS=1: EXP for 2 steps, then INF. infectCount=1.
- Step gating: in EXP, with step=0 for 20 cycles, state and timer are unchanged. Asserting step then resumes the countdown.
- Immunity: force INF with RECOV_THRESH=32'hFFFFFFFF (always recover) and IMMUNE_STEPS=3. Required: INF→REC, and REC for exactly 3 steps with neighbourEdges=all ones ignored, then SUS. Re-infection is then allowed on the next step.
- Output edges: in INF with INFECT_THRESH=all ones, outputEdges=CONNECTIVITY ('h23). In SUS, EXP and REC, outputEdges=0.
- Corners:
  - EXP_STEPS=0: SUS→INF goes direct.
  - infectCount preloaded near 16'hFFFF by repeated cycles: saturates at 16'hFFFF.
  - loadState and step in the same cycle: the load wins.
  - rst_n pulsed mid-EXP: immediate return to SUS.
